rvh_pmp_chk_arb: RTL

//   Shares the single permission-check port of rvh_pmp among REQ_COUNT requesters (e.g. ITLB, DTLB, PTW).

---
 rtl/rvh_pmp_chk_arb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rvh_pmp_chk_arb.sv
// Round-robin arbiter sharing the rvh_pmp permission-check port among MMU requesters.
// New checks are held off around pmpcfg/pmpaddr writes so no check sees a half-updated PMP.
module rvh_pmp_chk_arb #(
    parameter int REQ_COUNT    = 3,
    parameter int PADDR_WIDTH  = 56,
    parameter int REQ_ID_WIDTH = $clog2(REQ_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQ_COUNT-1:0]             req_vld_i,
    output logic [REQ_COUNT-1:0]             req_rdy_o,
    input  logic [REQ_COUNT*PADDR_WIDTH-1:0] req_paddr_i,
    input  logic [REQ_COUNT*2-1:0]           req_access_type_i,
    input  logic [REQ_COUNT*2-1:0]           req_priv_lvl_i,
    output logic [REQ_COUNT-1:0]             resp_vld_o,
    output logic [REQ_COUNT-1:0]             resp_fail_o,
    input  logic                             pmp_cfg_update_i,
    output logic                             pmp_check_vld_o,
    output logic [PADDR_WIDTH-1:0]           pmp_check_paddr_o,
    output logic [1:0]                       pmp_check_access_type_o,
    output logic [1:0]                       pmp_priv_lvl_o,
    input  logic                             pmp_check_fail_i
);

    typedef enum logic {
        OPEN,
        BLOCK
    } blk_state_e;

    blk_state_e              blk_state;
    blk_state_e              blk_nxt;
    logic                    arb_en;
    logic [REQ_ID_WIDTH-1:0] rr_ptr;
    logic [REQ_COUNT-1:0]    hi_mask;
    logic [REQ_COUNT-1:0]    hi_req;
    logic [REQ_COUNT-1:0]    pick;
    logic [REQ_COUNT-1:0]    gnt_oh;
    logic [REQ_ID_WIDTH-1:0] gnt_idx;
    logic                    found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_state <= OPEN;
        end else begin
            blk_state <= blk_nxt;
        end
    end

    // BLOCK is entered after any update cycle, so the cycle after a write is grant-free too
    always_comb begin
        blk_nxt = blk_state;
        arb_en  = 1'b0;
        unique case (blk_state)
            OPEN: begin
                if (pmp_cfg_update_i) begin
                    blk_nxt = BLOCK;
                end else begin
                    arb_en = 1'b1;
                end
            end
            BLOCK: begin
                if (!pmp_cfg_update_i) begin
                    blk_nxt = OPEN;
                end
            end
            default: blk_nxt = OPEN;
        endcase
    end

    // Prefer requests at or above rr_ptr; fall back to the lowest index to wrap
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            hi_mask[k] = (REQ_ID_WIDTH'(k) >= rr_ptr);
        end
        hi_req  = req_vld_i & hi_mask;
        pick    = (|hi_req) ? hi_req : req_vld_i;
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            if (!found && pick[k]) begin
                found     = 1'b1;
                gnt_oh[k] = 1'b1;
                gnt_idx   = REQ_ID_WIDTH'(k);
            end
        end
    end

    assign req_rdy_o       = gnt_oh & {REQ_COUNT{arb_en & ~rst}};
    assign pmp_check_vld_o = |req_rdy_o;

    always_comb begin
        pmp_check_paddr_o       = '0;
        pmp_check_access_type_o = '0;
        pmp_priv_lvl_o          = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            if (req_rdy_o[k]) begin
                pmp_check_paddr_o       |= req_paddr_i[k*PADDR_WIDTH +: PADDR_WIDTH];
                pmp_check_access_type_o |= req_access_type_i[k*2 +: 2];
                pmp_priv_lvl_o          |= req_priv_lvl_i[k*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (pmp_check_vld_o) begin
            if (gnt_idx == REQ_ID_WIDTH'(REQ_COUNT - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_vld_o  <= '0;
            resp_fail_o <= '0;
        end else begin
            resp_vld_o  <= req_rdy_o;
            resp_fail_o <= req_rdy_o & {REQ_COUNT{pmp_check_fail_i}};
        end
    end

endmodule
